// File: rtl/hongwai_pkg.sv
// Shared types and defaults for the hongwai IR transmitter: frame states,
// 50 MHz timing defaults and the two command-word widths.
package hongwai_pkg;

  localparam int unsigned W_D1 = 35;
  localparam int unsigned W_D2 = 32;

  localparam int unsigned DEF_CARRIER_PERIOD = 1316;
  localparam int unsigned DEF_CARRIER_HIGH   = 658;
  localparam int unsigned DEF_HDR_MARK       = 450000;
  localparam int unsigned DEF_HDR_SPACE      = 225000;
  localparam int unsigned DEF_BIT_MARK       = 28000;
  localparam int unsigned DEF_ZERO_SPACE     = 28000;
  localparam int unsigned DEF_ONE_SPACE      = 84500;
  localparam int unsigned DEF_LINK_SPACE     = 1000000;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_M, S_HDR_S, S_D1_M, S_D1_S,
    S_LNK_M, S_LNK_S, S_D2_M, S_D2_S, S_STOP_M
  } state_t;

  function automatic logic is_mark(state_t s);
    return s inside {S_HDR_M, S_D1_M, S_LNK_M, S_D2_M, S_STOP_M};
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier generator: registered square wave while enabled, phase forced back
// to the start of the high half whenever a new mark begins.
module ir_carrier_gen
  import hongwai_pkg::*;
#(
  parameter int unsigned CARRIER_PERIOD = DEF_CARRIER_PERIOD,
  parameter int unsigned CARRIER_HIGH   = DEF_CARRIER_HIGH
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_restart,
  output logic o_car
);

  logic [31:0] r_phase;
  logic        r_car;
  logic [31:0] w_phase_nxt;

  assign w_phase_nxt = (r_phase >= CARRIER_PERIOD - 1) ? '0 : r_phase + 32'd1;

  // r_phase is the phase of the cycle currently being driven on o_car
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
      r_car   <= 1'b0;
    end else if (i_restart) begin
      r_phase <= '0;
      r_car   <= (CARRIER_HIGH != 0);
    end else if (i_en) begin
      r_phase <= w_phase_nxt;
      r_car   <= (w_phase_nxt < CARRIER_HIGH);
    end else begin
      r_phase <= '0;
      r_car   <= 1'b0;
    end
  end

  assign o_car = r_car;

endmodule

// File: rtl/hongwai_ir_tx.sv
// IR remote transmitter: leader, 35-bit word, link gap, 32-bit word, stop.
// Define IR_CARRIER_EN to modulate marks; otherwise marks are a steady 1.
module hongwai_ir_tx
  import hongwai_pkg::*;
#(
  parameter int unsigned CARRIER_PERIOD = DEF_CARRIER_PERIOD,
  parameter int unsigned CARRIER_HIGH   = DEF_CARRIER_HIGH,
  parameter int unsigned HDR_MARK       = DEF_HDR_MARK,
  parameter int unsigned HDR_SPACE      = DEF_HDR_SPACE,
  parameter int unsigned BIT_MARK       = DEF_BIT_MARK,
  parameter int unsigned ZERO_SPACE     = DEF_ZERO_SPACE,
  parameter int unsigned ONE_SPACE      = DEF_ONE_SPACE,
  parameter int unsigned LINK_SPACE     = DEF_LINK_SPACE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_1,
  input  logic [W_D1-1:0] IR_in_data35,
  input  logic [W_D2-1:0] IR_in_data32,
  output logic            IR_out,
  output logic            led_out
);

  localparam logic [5:0] LAST_D1 = 6'(W_D1 - 1);
  localparam logic [5:0] LAST_D2 = 6'(W_D2 - 1);

  if (CARRIER_PERIOD == 0 || CARRIER_HIGH > CARRIER_PERIOD) begin : g_bad_carrier
    $error("hongwai_ir_tx: CARRIER_HIGH must not exceed a nonzero CARRIER_PERIOD");
  end

  logic [1:0]      r_sync;
  logic            r_key_d;
  state_t          r_state;
  logic [31:0]     r_cnt;
  logic [5:0]      r_bit;
  logic [W_D1-1:0] r_d1;
  logic [W_D2-1:0] r_d2;
  logic            r_led;

  logic w_rise, w_mark, w_adv, w_mark_nxt;

  assign w_rise = r_sync[1] & ~r_key_d;
  assign w_mark = is_mark(r_state);
  assign w_adv  = (r_state == S_IDLE) ? w_rise : (r_cnt == '0);
  // Every transition alternates mark/space, so advancing flips the mark level
  assign w_mark_nxt = w_mark ? ~w_adv : w_adv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '0;
      r_key_d <= 1'b0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_led   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], key_1};
      r_key_d <= r_sync[1];
      if (w_adv) begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_HDR_M;
            r_cnt   <= HDR_MARK - 1;
            r_d1    <= IR_in_data35;
            r_d2    <= IR_in_data32;
            r_bit   <= '0;
            r_led   <= 1'b1;
          end
          S_HDR_M: begin
            r_state <= S_HDR_S;
            r_cnt   <= HDR_SPACE - 1;
          end
          S_HDR_S: begin
            r_state <= S_D1_M;
            r_cnt   <= BIT_MARK - 1;
          end
          S_D1_M: begin
            r_state <= S_D1_S;
            r_cnt   <= r_d1[0] ? ONE_SPACE - 1 : ZERO_SPACE - 1;
          end
          S_D1_S: begin
            r_d1  <= r_d1 >> 1;
            r_cnt <= BIT_MARK - 1;
            if (r_bit == LAST_D1) begin
              r_state <= S_LNK_M;
              r_bit   <= '0;
            end else begin
              r_state <= S_D1_M;
              r_bit   <= r_bit + 6'd1;
            end
          end
          S_LNK_M: begin
            r_state <= S_LNK_S;
            r_cnt   <= LINK_SPACE - 1;
          end
          S_LNK_S: begin
            r_state <= S_D2_M;
            r_cnt   <= BIT_MARK - 1;
          end
          S_D2_M: begin
            r_state <= S_D2_S;
            r_cnt   <= r_d2[0] ? ONE_SPACE - 1 : ZERO_SPACE - 1;
          end
          S_D2_S: begin
            r_d2  <= r_d2 >> 1;
            r_cnt <= BIT_MARK - 1;
            if (r_bit == LAST_D2) begin
              r_state <= S_STOP_M;
              r_bit   <= '0;
            end else begin
              r_state <= S_D2_M;
              r_bit   <= r_bit + 6'd1;
            end
          end
          S_STOP_M: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_led   <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_led   <= 1'b0;
          end
        endcase
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt - 32'd1;
      end
    end
  end

  assign led_out = r_led;

`ifdef IR_CARRIER_EN
  logic w_start, w_car;
  assign w_start = w_adv & ~w_mark;

  ir_carrier_gen #(
    .CARRIER_PERIOD(CARRIER_PERIOD),
    .CARRIER_HIGH  (CARRIER_HIGH)
  ) u_car (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_mark_nxt),
    .i_restart(w_start),
    .o_car    (w_car)
  );

  assign IR_out = w_car;
`else
  logic r_ir;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ir <= 1'b0;
    else      r_ir <= w_mark_nxt;
  end

  assign IR_out = r_ir;
`endif

endmodule

// File: tb/tb_hongwai_ir_tx.sv
// Directed bench for hongwai_ir_tx using shortened timing values.
module tb_hongwai_ir_tx;

  localparam int CP = 4;
  localparam int CH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_1 = 1'b0;
  logic [34:0] d35 = '0;
  logic [31:0] d32 = '0;
  logic        IR_out;
  logic        led_out;

  int checks = 0;
  int failures = 0;

  logic tr [0:2047];
  logic ex [0:2047];

  always #5 clk = ~clk;

  hongwai_ir_tx #(
    .CARRIER_PERIOD(CP),
    .CARRIER_HIGH  (CH),
    .HDR_MARK      (40),
    .HDR_SPACE     (20),
    .BIT_MARK      (4),
    .ZERO_SPACE    (4),
    .ONE_SPACE     (12),
    .LINK_SPACE    (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_1       (key_1),
    .IR_in_data35(d35),
    .IR_in_data32(d32),
    .IR_out      (IR_out),
    .led_out     (led_out)
  );

  function automatic logic car(input int t);
`ifdef IR_CARRIER_EN
    return (t % CP) < CH;
`else
    return 1'b1;
`endif
  endfunction

  task automatic add_seg(inout int p, input int dur, input bit mk);
    for (int t = 0; t < dur; t++) ex[p + t] = mk ? car(t) : 1'b0;
    p += dur;
  endtask

  task automatic build_exp(input logic [34:0] a, input logic [31:0] b, output int n);
    n = 0;
    add_seg(n, 40, 1); add_seg(n, 20, 0);
    for (int i = 0; i < 35; i++) begin add_seg(n, 4, 1); add_seg(n, a[i] ? 12 : 4, 0); end
    add_seg(n, 4, 1); add_seg(n, 50, 0);
    for (int i = 0; i < 32; i++) begin add_seg(n, 4, 1); add_seg(n, b[i] ? 12 : 4, 0); end
    add_seg(n, 4, 1);
  endtask

  // Press the key and record IR_out for every cycle led_out is high.
  task automatic capture(input logic [34:0] a, input logic [31:0] b, input bit pulse_mid,
                         output int lat, output int len);
    d35 = a; d32 = b;
    @(negedge clk); key_1 = 1'b1;
    lat = 0; len = 0;
    while (led_out !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    while (led_out === 1'b1 && len < 2000) begin
      tr[len] = IR_out;
      len++;
      if (len == 5) key_1 = 1'b0;
      if (len == 10) begin d35 = ~a; d32 = ~b; end
      if (pulse_mid && len == 300) key_1 = 1'b1;
      if (pulse_mid && len == 306) key_1 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic run_and_check(input string nm, input logic [34:0] a, input logic [31:0] b,
                               input bit pulse_mid, input int exp_len);
    int lat, len, n, bad, first_bad, run, k, extra;
    logic [34:0] g35;
    logic [31:0] g32;
    capture(a, b, pulse_mid, lat, len);
    build_exp(a, b, n);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL %s latency: got %0d edges, expected 3", nm, lat); end
    checks++;
    if (len !== exp_len) begin failures++; $display("FAIL %s length: got %0d, expected %0d", nm, len, exp_len); end
    bad = 0; first_bad = -1;
    for (int i = 0; i < n; i++) if (tr[i] !== ex[i]) begin bad++; if (first_bad < 0) first_bad = i; end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s waveform: %0d cycles differ, first at %0d got %b expected %b",
               nm, bad, first_bad, tr[first_bad], ex[first_bad]);
    end
    // Low runs of 3+ cycles are the spaces; internal carrier gaps are 2 cycles
    g35 = '0; g32 = '0; run = 0; k = 0;
    for (int i = 0; i < len; i++) begin
      if (tr[i] === 1'b1) begin
        if (run >= 3) begin
          if (k >= 1 && k <= 35) g35[k - 1] = (run > 8);
          if (k >= 37 && k <= 68) g32[k - 37] = (run > 8);
          k++;
        end
        run = 0;
      end else run++;
    end
    checks++;
    if (k !== 69) begin failures++; $display("FAIL %s space count: got %0d, expected 69", nm, k); end
    checks++;
    if (g35 !== a) begin failures++; $display("FAIL %s word35: got %h, expected %h", nm, g35, a); end
    checks++;
    if (g32 !== b) begin failures++; $display("FAIL %s word32: got %h, expected %h", nm, g32, b); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (led_out !== 1'b0 || IR_out !== 1'b0) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL %s idle after frame: %0d busy cycles, expected 0", nm, extra); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      key_1 = ~key_1;
      checks++;
      if (IR_out !== 1'b0 || led_out !== 1'b0) begin
        failures++;
        $display("FAIL reset hold: IR_out=%b led_out=%b, expected 0 0", IR_out, led_out);
      end
    end
    key_1 = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (IR_out !== 1'b0 || led_out !== 1'b0) begin
      failures++;
      $display("FAIL reset release: IR_out=%b led_out=%b, expected 0 0", IR_out, led_out);
    end
  endtask

  task automatic test_zero();
    run_and_check("zero", 35'd0, 32'd0, 1'b0, 654);
  endtask

  task automatic test_pattern();
    run_and_check("pattern", 35'b11111000001111100000111110000011111,
                  32'b11111000001111100000111110000011, 1'b0, 950);
  endtask

  task automatic test_retrigger();
    run_and_check("retrigger", 35'b11111000001111100000111110000011111,
                  32'b11111000001111100000111110000011, 1'b1, 950);
  endtask

  task automatic test_abort();
    int lat, idx, busy;
    d35 = '0; d32 = '0;
    @(negedge clk); key_1 = 1'b1;
    lat = 0;
    while (led_out !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    key_1 = 1'b0;
    checks++;
    if (led_out !== 1'b1) begin failures++; $display("FAIL abort start: led_out=%b, expected 1", led_out); end
    // index 498 is the first cycle of the D2 bit-13 mark for all-zero data
    for (idx = 0; idx < 498; idx++) @(negedge clk);
    checks++;
    if (IR_out !== 1'b1 || led_out !== 1'b1) begin
      failures++;
      $display("FAIL abort pre: IR_out=%b led_out=%b, expected 1 1", IR_out, led_out);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (IR_out !== 1'b0 || led_out !== 1'b0) begin
      failures++;
      $display("FAIL abort immediate: IR_out=%b led_out=%b, expected 0 0", IR_out, led_out);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (IR_out !== 1'b0 || led_out !== 1'b0) busy++;
    end
    checks++;
    if (busy != 0) begin failures++; $display("FAIL abort idle: %0d busy cycles, expected 0", busy); end
    run_and_check("after_abort", 35'd0, 32'd0, 1'b0, 654);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_pattern();
    test_retrigger();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
